cfg_frame_loader: RTL

- Configuration write sequencer that sits directly upstream of the logic-element tile's configuration port.
- Accepts a stream of (address, data-bit) configuration words over a valid/ready handshake and buffers them in a small FIFO.
- Replays each buffered word to the tile's enable/address/data_in port with a fixed setup/strobe/hold sequence.
- Reports progress, completion and out-of-range address errors to the bitstream controller.

---
 rtl/cfg_loader_pkg.sv | 23 ++
 rtl/cfg_word_fifo.sv | 68 ++++++
 rtl/cfg_frame_loader.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/cfg_loader_pkg.sv
// Shared definitions for the configuration frame loader.
//   state_e     : write sequencer states
//   cfg_entry_t : buffered word layout {addr, data, last} at the default address width
//   DEF_ADDR_W / DEF_MAX_ADDR : default address width and highest legal address
package cfg_loader_pkg;

  localparam int DEF_ADDR_W   = 5;
  localparam int DEF_MAX_ADDR = 19;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_e;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] addr;
    logic                  data;
    logic                  last;
  } cfg_entry_t;

endpackage

// File: rtl/cfg_word_fifo.sv
// Synchronous FIFO for buffered configuration words.
//   clk, reset (active-low, synchronous)
//   push/wdata : write one entry when not full
//   pop/rdata  : rdata always shows the head; pop advances when not empty
//   full, empty, count : occupancy status
module cfg_word_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 7
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two; count separates full from empty.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; occupancy is tracked by the control flops above.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/cfg_frame_loader.sv
// Configuration write sequencer feeding the logic-element tile configuration port.
//   clk, reset (active-low, synchronous)
//   cfg_valid/cfg_ready/cfg_addr/cfg_data/cfg_last : upstream word handshake
//   enable/address/data_in : tile write port (setup, one-cycle strobe, hold)
//   busy        : words buffered or a write in progress
//   done        : sticky, frame's last word handled
//   err_addr    : sticky, out-of-range address received
//   write_count : strobes issued since reset, saturating
module cfg_frame_loader
  import cfg_loader_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int MAX_ADDR   = DEF_MAX_ADDR,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic              cfg_data,
  input  logic              cfg_last,
  output logic              enable,
  output logic [ADDR_W-1:0] address,
  output logic              data_in,
  output logic              busy,
  output logic              done,
  output logic              err_addr,
  output logic [CNT_W-1:0]  write_count
);

  localparam int FCW = $clog2(FIFO_DEPTH) + 1;
  localparam int PCW = FCW + 1;
  localparam int EW  = ADDR_W + 2;
  localparam logic [ADDR_W:0] MAX_A = (ADDR_W + 1)'(MAX_ADDR);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              data;
    logic              last;
  } entry_t;

  entry_t            push_e, head_e;
  logic [EW-1:0]     head_bits;
  logic              accept, in_range, push, pop, full, empty;
  logic [FCW-1:0]    fcount;
  logic [PCW-1:0]    ahead;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              data_q, data_d;
  logic              last_q, last_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pend_q, pend_d;
  logic [PCW-1:0]    pend_cnt_q, pend_cnt_d;

  assign cfg_ready = reset && !full;
  assign accept    = cfg_valid && cfg_ready;
  assign in_range  = ({1'b0, cfg_addr} <= MAX_A);
  assign push      = accept && in_range;
  assign push_e    = '{addr: cfg_addr, data: cfg_data, last: cfg_last};
  assign head_e    = head_bits;

  cfg_word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (push_e),
    .pop   (pop),
    .rdata (head_bits),
    .full  (full),
    .empty (empty),
    .count (fcount)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    data_d     = data_q;
    last_d     = last_q;
    done_d     = done_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    pend_d     = pend_q;
    pend_cnt_d = pend_cnt_q;
    pop        = 1'b0;
    ahead      = '0;

    case (state_q)
      IDLE, HOLD: begin
        if (!empty) begin
          pop     = 1'b1;
          addr_d  = head_e.addr;
          data_d  = head_e.data;
          last_d  = head_e.last;
          state_d = SETUP;
        end else begin
          state_d = IDLE;
        end
      end
      SETUP:  state_d = STROBE;
      STROBE: begin
        if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        // done becomes visible as HOLD is entered
        if (last_q) done_d = 1'b1;
        state_d = HOLD;
      end
      default: state_d = IDLE;
    endcase

    // A rejected last word waits for every word already accepted ahead of it;
    // pend_cnt counts those still to be strobed.
    if (pend_q && state_q == STROBE) begin
      if (pend_cnt_q == PCW'(1)) begin
        done_d = 1'b1;
        pend_d = 1'b0;
      end else begin
        pend_cnt_d = pend_cnt_q - PCW'(1);
      end
    end

    if (accept && !in_range) begin
      err_d = 1'b1;
      if (cfg_last) begin
        // Word in SETUP is still owed a strobe; a word in STROBE finishes on this edge.
        ahead = {1'b0, fcount} + PCW'(state_q == SETUP);
        if (ahead == '0) begin
          done_d = 1'b1;
          pend_d = 1'b0;
        end else begin
          pend_d     = 1'b1;
          pend_cnt_d = ahead;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      data_q     <= 1'b0;
      last_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
      pend_q     <= 1'b0;
      pend_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      last_q     <= last_d;
      done_q     <= done_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      pend_cnt_q <= pend_cnt_d;
    end
  end

  assign enable      = (state_q == STROBE);
  assign address     = addr_q;
  assign data_in     = data_q;
  assign busy        = (fcount != '0) || (state_q != IDLE);
  assign done        = done_q;
  assign err_addr    = err_q;
  assign write_count = cnt_q;

endmodule
